// File: rtl/obi_mem_responder.sv
// rtl/obi_mem_responder.sv - OBI slave in front of a 1-cycle-latency SRAM with an in-order response FIFO.
// Credit gating keeps the FIFO from ever overflowing, so the SRAM read data never needs a stall path.
module obi_mem_responder #(
    parameter int MEM_AW = 14,
    parameter int DEPTH  = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              obi_req_i,
    output logic              obi_gnt_o,
    input  logic [31:0]       obi_addr_i,
    input  logic              obi_we_i,
    input  logic [3:0]        obi_be_i,
    input  logic [31:0]       obi_wdata_i,
    output logic              obi_rvalid_o,
    input  logic              obi_rready_i,
    output logic [31:0]       obi_rdata_o,
    output logic              obi_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_inflight;
    logic          r_inf_rd;
    logic          r_inf_oor;
    logic [31:0]   r_data [DEPTH];
    logic          r_err  [DEPTH];

    logic          w_in_range;
    logic          w_accept;
    logic [CW:0]   w_busy;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_push_data;
    logic          w_unused;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    assign w_in_range = (obi_addr_i[31:MEM_AW+2] == '0);
    assign w_unused   = &{1'b0, obi_addr_i[1:0]};

    // Entries already queued plus the one whose SRAM read lands next edge.
    assign w_busy    = {1'b0, r_count} + (CW + 1)'(r_inflight);
    assign obi_gnt_o = obi_req_i && !rst_i && (w_busy < DEPTH_W);
    assign w_accept  = obi_req_i && obi_gnt_o;

    assign mem_req_o   = w_accept && w_in_range;
    assign mem_we_o    = obi_we_i;
    assign mem_be_o    = obi_be_i;
    assign mem_addr_o  = obi_addr_i[MEM_AW+1:2];
    assign mem_wdata_o = obi_wdata_i;

    assign w_push      = r_inflight;
    assign w_push_data = r_inf_rd ? mem_rdata_i : 32'h0;

    assign obi_rvalid_o = (r_count != '0);
    assign w_pop        = obi_rvalid_o && obi_rready_i;
    assign obi_rdata_o  = obi_rvalid_o ? r_data[r_rptr] : 32'h0;
    assign obi_err_o    = obi_rvalid_o ? r_err[r_rptr] : 1'b0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_inflight <= 1'b0;
            r_inf_rd   <= 1'b0;
            r_inf_oor  <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= w_accept;
            r_inf_rd   <= w_accept && w_in_range && !obi_we_i;
            r_inf_oor  <= w_accept && !w_in_range;
            if (w_push) begin
                r_wptr <= ptr_next(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_next(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_data[r_wptr] <= w_push_data;
            r_err[r_wptr]  <= r_inf_oor;
        end
    end

endmodule

// File: tb/tb_obi_mem_responder.sv
// tb/tb_obi_mem_responder.sv - randomized self-checking bench for obi_mem_responder against a transaction-level model.
module tb_obi_mem_responder;

    localparam int MEM_AW = 14;
    localparam int DEPTH  = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              obi_req = 1'b0;
    logic              obi_gnt;
    logic [31:0]       obi_addr = 32'h0;
    logic              obi_we = 1'b0;
    logic [3:0]        obi_be = 4'hF;
    logic [31:0]       obi_wdata = 32'h0;
    logic              obi_rvalid;
    logic              obi_rready = 1'b1;
    logic [31:0]       obi_rdata;
    logic              obi_err;
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = 32'h0;

    obi_mem_responder #(.MEM_AW(MEM_AW), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst),
        .obi_req_i(obi_req), .obi_gnt_o(obi_gnt), .obi_addr_i(obi_addr),
        .obi_we_i(obi_we), .obi_be_i(obi_be), .obi_wdata_i(obi_wdata),
        .obi_rvalid_o(obi_rvalid), .obi_rready_i(obi_rready),
        .obi_rdata_o(obi_rdata), .obi_err_o(obi_err),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [31:0] sram    [0:(1<<MEM_AW)-1];
    logic [31:0] ref_mem [0:(1<<MEM_AW)-1];

    logic [32:0] exp_q[$];
    logic [32:0] obs_q[$];
    int          acc_cyc_q[$];
    int          obs_cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    // Transaction-level model: every accepted request produces exactly one expected response, in order.
    always @(negedge clk) begin
        if (!rst) begin
            if (obi_req && obi_gnt) begin
                if (obi_addr[31:MEM_AW+2] != '0) begin
                    exp_q.push_back({32'h0, 1'b1});
                end else if (obi_we) begin
                    for (int b = 0; b < 4; b++)
                        if (obi_be[b]) ref_mem[obi_addr[MEM_AW+1:2]][8*b +: 8] = obi_wdata[8*b +: 8];
                    exp_q.push_back({32'h0, 1'b0});
                end else begin
                    exp_q.push_back({ref_mem[obi_addr[MEM_AW+1:2]], 1'b0});
                end
                acc_cyc_q.push_back(cyc);
            end
            if (obi_rvalid && obi_rready) begin
                obs_q.push_back({obi_rdata, obi_err});
                obs_cyc_q.push_back(cyc);
            end
        end
    end

    task automatic clear_q();
        exp_q.delete();
        obs_q.delete();
        acc_cyc_q.delete();
        obs_cyc_q.delete();
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        @(posedge clk); #1;
        obi_req    = 1'b0;
        obi_rready = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (obs_q.size() == exp_q.size() && !obi_rvalid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd);
        obi_req   = 1'b1;
        obi_addr  = a;
        obi_we    = we;
        obi_be    = be;
        obi_wdata = wd;
    endtask

    task automatic test_reset();
        bit ok;
        drive(32'h0, 1'b0, 4'hF, 32'h0);
        #1;
        n_tests++;
        if (obi_gnt !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_gnt gnt=%b mem_req=%b want 0 0", obi_gnt, mem_req);
        end
        n_tests++;
        if (obi_rvalid !== 1'b0 || obi_rdata !== 32'h0 || obi_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_resp rvalid=%b rdata=%h err=%b want 0 0 0", obi_rvalid, obi_rdata, obi_err);
        end
        obi_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(32'h0000_0040, 1'b0, 4'hF, 32'h0);
        @(negedge clk);
        n_tests++;
        if (obi_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_grant gnt=%b want 1", obi_gnt);
        end
        wait_idle(50, ok);
        n_tests++;
        if (!ok || obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL reset_first_resp ok=%b n=%0d got %h want %h", ok, obs_q.size(),
                     (obs_q.size() > 0) ? obs_q[0] : 33'h0, exp_q[0]);
        end
        clear_q();
    endtask

    task automatic test_single_read();
        bit ok;
        sram[5]    = 32'hDEAD_BEEF;
        ref_mem[5] = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        drive(32'h0000_0014, 1'b0, 4'hF, 32'h0);
        @(negedge clk);
        n_tests++;
        if (obi_gnt !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 14'd5 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL single_addr gnt=%b mem_req=%b addr=%0d we=%b want 1 1 5 0", obi_gnt, mem_req, mem_addr, mem_we);
        end
        wait_idle(50, ok);
        n_tests++;
        if (!ok || obs_q.size() != 1) begin
            n_fail++;
            $display("FAIL single_count ok=%b got %0d want 1", ok, obs_q.size());
        end else begin
            n_tests++;
            if (obs_q[0] !== {32'hDEAD_BEEF, 1'b0}) begin
                n_fail++;
                $display("FAIL single_data got %h want %h", obs_q[0], {32'hDEAD_BEEF, 1'b0});
            end
            n_tests++;
            if (obs_cyc_q[0] - acc_cyc_q[0] != 2) begin
                n_fail++;
                $display("FAIL single_latency got %0d want 2", obs_cyc_q[0] - acc_cyc_q[0]);
            end
        end
        clear_q();
    endtask

    task automatic test_byte_write();
        bit ok;
        logic [31:0] old;
        old = ref_mem[2];
        @(posedge clk); #1;
        drive(32'h0000_0008, 1'b1, 4'b0010, 32'h0000_AB00);
        @(posedge clk); #1;
        drive(32'h0000_0008, 1'b0, 4'hF, 32'h0);
        wait_idle(50, ok);
        n_tests++;
        if (!ok || obs_q.size() != 2) begin
            n_fail++;
            $display("FAIL bytewr_count ok=%b got %0d want 2", ok, obs_q.size());
        end else begin
            n_tests++;
            if (obs_q[0] !== 33'h0) begin
                n_fail++;
                $display("FAIL bytewr_wresp got %h want 0", obs_q[0]);
            end
            n_tests++;
            if (obs_q[1] !== {old[31:16], 8'hAB, old[7:0], 1'b0}) begin
                n_fail++;
                $display("FAIL bytewr_read got %h want %h", obs_q[1], {old[31:16], 8'hAB, old[7:0], 1'b0});
            end
        end
        clear_q();
    endtask

    task automatic test_backpressure();
        bit ok;
        int ngnt = 0;
        bit have = 1'b0;
        bit resumed = 1'b0;
        logic [31:0] head = 32'h0;
        @(posedge clk); #1;
        obi_rready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            drive({16'h0, 2'b0, 12'(c + 16), 2'b00}, 1'b0, 4'hF, 32'h0);
            @(negedge clk);
            if (obi_gnt) ngnt++;
            if (obi_rvalid) begin
                if (!have) begin
                    head = obi_rdata;
                    have = 1'b1;
                end else begin
                    n_tests++;
                    if (obi_rdata !== head) begin
                        n_fail++;
                        $display("FAIL bp_head_stable cycle %0d got %h want %h", c, obi_rdata, head);
                    end
                end
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (ngnt != DEPTH) begin
            n_fail++;
            $display("FAIL bp_grants got %0d want %0d", ngnt, DEPTH);
        end
        n_tests++;
        if (!have || exp_q.size() == 0 || head !== exp_q[0][32:1]) begin
            n_fail++;
            $display("FAIL bp_head got %h want %h", head, (exp_q.size() > 0) ? exp_q[0][32:1] : 32'h0);
        end
        obi_rready = 1'b1;
        for (int c = 0; c < 4 && !resumed; c++) begin
            @(negedge clk);
            if (obi_gnt) resumed = 1'b1;
            @(posedge clk); #1;
        end
        obi_req = 1'b0;
        n_tests++;
        if (!resumed) begin
            n_fail++;
            $display("FAIL bp_resume no grant after rready got 0 want 1");
        end
        wait_idle(50, ok);
        n_tests++;
        if (!ok || obs_q.size() != exp_q.size() || obs_q.size() != DEPTH + 1) begin
            n_fail++;
            $display("FAIL bp_count ok=%b got %0d want %0d", ok, obs_q.size(), DEPTH + 1);
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL bp_order[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        clear_q();
    endtask

    task automatic test_out_of_range();
        bit ok;
        @(posedge clk); #1;
        drive(32'h0001_0000, 1'b0, 4'hF, 32'h0);
        @(negedge clk);
        n_tests++;
        if (obi_gnt !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_strobe gnt=%b mem_req=%b want 1 0", obi_gnt, mem_req);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            drive({16'($urandom_range(1, 16'hFFFF)), 16'($urandom)}, 1'($urandom), 4'($urandom), $urandom);
        end
        wait_idle(60, ok);
        n_tests++;
        if (!ok || obs_q.size() != 5) begin
            n_fail++;
            $display("FAIL oor_count ok=%b got %0d want 5", ok, obs_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_tests++;
                if (obs_q[i] !== {32'h0, 1'b1}) begin
                    n_fail++;
                    $display("FAIL oor_resp[%0d] got %h want %h", i, obs_q[i], {32'h0, 1'b1});
                end
            end
        end
        clear_q();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int ngnt = 0;
        int base;
        base = int'($urandom_range(0, 1000));
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            drive(32'((base + i) * 4 + int'($urandom_range(0, 3))), 1'b0, 4'hF, 32'h0);
            @(negedge clk);
            if (obi_gnt) ngnt++;
            @(posedge clk); #1;
        end
        obi_req = 1'b0;
        n_tests++;
        if (ngnt != 16) begin
            n_fail++;
            $display("FAIL b2b_grants got %0d want 16", ngnt);
        end
        wait_idle(60, ok);
        n_tests++;
        if (!ok || obs_q.size() != 16 || exp_q.size() != 16) begin
            n_fail++;
            $display("FAIL b2b_count ok=%b got %0d want 16", ok, obs_q.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_tests++;
                if (obs_q[i] !== {ref_mem[base + i], 1'b0} || obs_cyc_q[i] != acc_cyc_q[0] + 2 + i) begin
                    n_fail++;
                    $display("FAIL b2b[%0d] got %h @%0d want %h @%0d", i, obs_q[i], obs_cyc_q[i],
                             {ref_mem[base + i], 1'b0}, acc_cyc_q[0] + 2 + i);
                end
            end
        end
        clear_q();
    endtask

    task automatic test_random();
        bit ok;
        int acc = 0;
        int pop = 0;
        int gnt_err = 0;
        logic exp_gnt;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            obi_rready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) < 7) begin
                if ($urandom_range(0, 9) < 8)
                    drive({16'h0, 2'b0, 12'($urandom_range(0, 31)), 2'($urandom)}, 1'($urandom), 4'($urandom), $urandom);
                else
                    drive({16'($urandom_range(1, 16'hFFFF)), 16'($urandom)}, 1'($urandom), 4'($urandom), $urandom);
            end else begin
                obi_req = 1'b0;
            end
            @(negedge clk);
            exp_gnt = obi_req && ((acc - pop) < DEPTH);
            n_tests++;
            if (obi_gnt !== exp_gnt) begin
                n_fail++;
                gnt_err++;
                if (gnt_err < 5)
                    $display("FAIL rand_gnt cycle %0d got %b want %b", c, obi_gnt, exp_gnt);
            end
            if (obi_req && obi_gnt) acc++;
            if (obi_rvalid && obi_rready) pop++;
        end
        wait_idle(60, ok);
        n_tests++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count ok=%b got %0d want %0d", ok, obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rand_resp[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        clear_q();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int stale;
        logic [31:0] a;
        @(posedge clk); #1;
        obi_rready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(32'(64 + i * 4), 1'b0, 4'hF, 32'h0);
            @(posedge clk); #1;
        end
        obi_req = 1'b0;
        #2;
        rst = 1'b1;
        obi_req = 1'b1;
        #1;
        n_tests++;
        if (obi_rvalid !== 1'b0 || obi_rdata !== 32'h0 || obi_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_drop rvalid=%b rdata=%h err=%b want 0 0 0", obi_rvalid, obi_rdata, obi_err);
        end
        n_tests++;
        if (obi_gnt !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_gnt gnt=%b mem_req=%b want 0 0", obi_gnt, mem_req);
        end
        obi_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_q();
        obi_rready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        stale = obs_q.size();
        n_tests++;
        if (stale != 0) begin
            n_fail++;
            $display("FAIL rstmid_stale got %0d responses want 0", stale);
        end
        a = 32'($urandom_range(0, 4095)) << 2;
        drive(a, 1'b0, 4'hF, 32'h0);
        wait_idle(50, ok);
        n_tests++;
        if (!ok || obs_q.size() != 1 || obs_q[0] !== {ref_mem[a[15:2]], 1'b0}
            || obs_cyc_q[0] - acc_cyc_q[0] != 2) begin
            n_fail++;
            $display("FAIL rstmid_read ok=%b n=%0d got %h want %h", ok, obs_q.size(),
                     (obs_q.size() > 0) ? obs_q[0] : 33'h0, {ref_mem[a[15:2]], 1'b0});
        end
        clear_q();
    endtask

    initial begin
        for (int i = 0; i < (1 << MEM_AW); i++) begin
            sram[i]    = $urandom;
            ref_mem[i] = sram[i];
        end
        test_reset();
        test_single_read();
        test_byte_write();
        test_backpressure();
        test_out_of_range();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/obi_mem_responder.md
OBI_MEM_RESPONDER -- requirements
Module: obi_mem_responder

Interface
REQ-001 Parameter MEM_AW, default 14: SRAM word-address width (64 KiB).
REQ-002 Parameter DEPTH, default 3: response FIFO depth; legal range 2..8.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 obi_req_i  in  1  OBI address-phase request.
REQ-006 obi_gnt_o  out  1  OBI grant.
REQ-007 obi_addr_i  in  32  byte address.
REQ-008 obi_we_i  in  1  1 = write, 0 = read.
REQ-009 obi_be_i  in  4  byte enables.
REQ-010 obi_wdata_i  in  32  write data.
REQ-011 obi_rvalid_o  out  1  response valid.
REQ-012 obi_rready_i  in  1  initiator ready for the response.
REQ-013 obi_rdata_o  out  32  read data; 0 for write responses.
REQ-014 obi_err_o  out  1  response error flag, qualified by obi_rvalid_o.
REQ-015 mem_req_o  out  1  SRAM access strobe.
REQ-016 mem_we_o  out  1  SRAM write enable.
REQ-017 mem_be_o  out  4  SRAM byte enables.
REQ-018 mem_addr_o  out  MEM_AW  SRAM word address.
REQ-019 mem_wdata_o  out  32  SRAM write data.
REQ-020 mem_rdata_i  in  32  SRAM read data, valid exactly 1 cycle after mem_req_o.

Function
REQ-021 Accepted transaction: obi_req_i && obi_gnt_o in the same cycle (the "accept cycle").
REQ-022 Credit = DEPTH - fifo_count - inflight, where inflight (0/1) marks a transaction accepted in the previous cycle.
REQ-023 obi_gnt_o = obi_req_i && credit > 0, combinational.
REQ-024 A pop in the current cycle does not raise credit until the next cycle; there is no bypass.
REQ-025 In-range address: obi_addr_i[31:MEM_AW+2] == 0.
REQ-026 In-range accept drives mem_req_o = 1 in the accept cycle.
  - mem_we_o = obi_we_i, mem_be_o = obi_be_i, mem_wdata_o = obi_wdata_i.
  - mem_addr_o = obi_addr_i[MEM_AW+1:2].
REQ-027 Out-of-range accept: grant is still issued, mem_req_o stays 0, and the response is {rdata 0, err 1}.
REQ-028 obi_addr_i[1:0] is ignored; no misalignment error is raised.
REQ-029 When no accept occurs, mem_req_o = 0; the other mem_* outputs are don't-care.
REQ-030 Push into the FIFO on the edge ending the cycle after accept.
  - Read: entry = {mem_rdata_i, err 0}.
  - Write: entry = {0, err 0}.
  - Out-of-range: entry = {0, err 1}.
REQ-031 obi_rvalid_o = FIFO not empty; obi_rdata_o and obi_err_o come from the FIFO head, registered.
REQ-032 Pop on obi_rvalid_o && obi_rready_i.
REQ-033 While obi_rvalid_o is high and obi_rready_i is low, the head is held stable.
REQ-034 Responses are returned strictly in accept order.
REQ-035 Latency: accept in cycle N gives the earliest obi_rvalid_o in cycle N+2.
REQ-036 Simultaneous push and pop in one cycle leaves fifo_count unchanged; both occur.
REQ-037 Read/write pointers wrap modulo DEPTH; a push when full cannot occur (credit prevents it).
REQ-038 With obi_rready_i held at 1 and DEPTH >= 3, one grant per cycle is sustained; with DEPTH = 2, two grants per three cycles.

Reset
REQ-039 rst_i asserted gives, immediately and asynchronously:
  - FIFO empty, inflight = 0, pointers = 0.
  - obi_rvalid_o = 0, obi_rdata_o = 0, obi_err_o = 0.
  - obi_gnt_o = 0 and mem_req_o = 0 while reset is high.
REQ-040 Transactions in flight or queued at reset are discarded; no response is ever issued for them.
REQ-041 The first grant is possible in the first cycle after rst_i deasserts.

Verification
REQ-042 Single read:
  - Stimulus: mem[5] = 0xDEADBEEF, read addr 0x14, rready = 1.
  - Response: gnt in cycle 0, mem_addr_o = 5 in cycle 0, rvalid with rdata 0xDEADBEEF and err 0 in cycle 2.
REQ-043 Byte write then read:
  - Stimulus: write addr 0x8, be = 0b0010, wdata 0x0000AB00; then read 0x8.
  - Response: write gives rdata 0 and err 0; read returns byte 1 = 0xAB with other bytes unchanged.
REQ-044 Backpressure:
  - Stimulus: rready = 0, req held high for 6 cycles.
  - Response: exactly 3 grants; rvalid stays high with the first response stable.
  - Then rready = 1: the 3 responses arrive in order and granting resumes.
REQ-045 Out-of-range:
  - Stimulus: read 0x0001_0000 (MEM_AW = 14).
  - Response: gnt = 1, mem_req_o = 0, response rdata 0 with err 1.
REQ-046 Throughput:
  - Stimulus: 16 back-to-back reads of consecutive words, rready = 1.
  - Response: 16 consecutive grant cycles and 16 consecutive rvalid cycles starting 2 cycles later, data in order.
REQ-047 Reset mid-operation:
  - Stimulus: rst_i asserted with 2 responses queued and 1 in flight.
  - Response: rvalid drops immediately; after deassertion no stale response appears and a new read completes with 2-cycle latency.
